column_writer: RTL and testbench
================================

COLUMN_WRITER -- requirements
Module: column_writer

Interface
REQ-001 Parameter COLUMNS, default 320, columns per frame (index width 9 bits).
REQ-002 clk  input  1  sole clock; all logic on posedge.
REQ-003 clr  input  1  reset; synchronous, active-high.
REQ-004 col_valid  input  1  producer has a column pending.
REQ-005 col_ready  output  1  column accepted when col_valid && col_ready at posedge.
REQ-006 col_distance  input  16  column distance word.
REQ-007 col_texture  input  16  column texture word.
REQ-008 read_address  output  16  shared-memory address, used for both reads and writes.
REQ-009 read_data  input  16  memory data, valid one cycle after read_address is presented.
REQ-010 write_enable  output  1  memory write strobe for write_data at read_address.
REQ-011 write_data  output  16  memory write word.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 frame_done  output  1  one-cycle pulse on the cycle after a flag publish.

Function
REQ-014 Memory map: DISTANCE_1 63488, TEXTURE_1 64000, DISTANCE_2 64512, TEXTURE_2 65024, FLAG 65535; flag bit0 = consumed, bit1 = buffer select.
REQ-015 States: IDLE, POLL_ADDR, POLL_CHECK, WRITE_DIST, WRITE_TEX, PUBLISH, DONE.
REQ-016 IDLE: index=0; col_ready=0; on col_valid go to POLL_ADDR.
REQ-017 POLL_ADDR: read_address=FLAG, write_enable=0; next POLL_CHECK.
REQ-018 POLL_CHECK: read_data bit0=1 -> latch target=~read_data[1], go WRITE_DIST; bit0=0 -> POLL_ADDR (poll indefinitely).
REQ-019 WRITE_DIST: col_ready=1; on handshake write col_distance to (target ? DISTANCE_2 : DISTANCE_1)+index, latch col_texture, go WRITE_TEX; no handshake -> stay, write_enable=0.
REQ-020 WRITE_TEX: col_ready=0; write latched texture to (target ? TEXTURE_2 : TEXTURE_1)+index; index==COLUMNS-1 -> PUBLISH, else index+1 -> WRITE_DIST.
REQ-021 PUBLISH: write_data={14'b0,target,1'b0} to FLAG; next DONE.
REQ-022 DONE: frame_done=1; index=0; next IDLE.
REQ-023 Throughput: at most one column per 2 cycles; a full frame with col_valid held high is 2*COLUMNS+1 cycles after the first handshake, including PUBLISH.
REQ-024 Address arithmetic: zero-extend 9-bit index to 16 bits, then add the offset; index never exceeds COLUMNS-1.
REQ-025 write_enable is high only in a WRITE_DIST handshake cycle, in WRITE_TEX and in PUBLISH; write_data otherwise is don't-care but held at 0.
REQ-026 col_valid deassert mid-frame: pause in WRITE_DIST; no timeout; frame resumes on the next handshake.
REQ-027 Flags are polled once per frame only; buffer target is fixed until PUBLISH.

Reset
REQ-028 clr=1: state IDLE, index 0, target 0, col_ready 0, write_enable 0, write_data 0, read_address FLAG, busy 0, frame_done 0.
REQ-029 Reset mid-frame abandons the partial buffer without a flag write; the next frame restarts at index 0 with a fresh poll.

Configuration
REQ-030 Macro COLUMN_WRITER_FRAME_COUNT_EN defined: add output frame_count[15:0], reset 0, +1 at each PUBLISH, wraps 65535->0.
REQ-031 Macro undefined: port and counter absent; all other behaviour identical.

Structure
REQ-032 Shared package gpu_pkg holds the five memory-map constants, COLUMNS default and the flag bit positions, shared with the GPU display side.
REQ-033 State encoding is local to column_writer.
REQ-034 Address selection uses the existing mux4 sub-module (inputs: distance address, texture address, FLAG, FLAG).

Verification
REQ-035 Flag memory=0x0001, 320 columns distance=i, texture=0x100+i streamed back-to-back -> mem[64512+i]=i, mem[65024+i]=0x100+i, mem[65535]=0x0002, frame_done pulse once.
REQ-036 Flag=0x0003 -> writes to 63488/64000 range, final flag 0x0000.
REQ-037 Flag=0x0000 for 50 cycles, then 0x0001 -> no column writes and col_ready=0 until bit0 is seen, then normal frame.
REQ-038 col_valid low for 10 cycles at index 100 -> no writes during the gap; data at 100 is correct; total write count 641.
REQ-039 clr pulse at index 200 -> no flag write; next frame polls and rewrites from index 0.
REQ-040 With COLUMN_WRITER_FRAME_COUNT_EN, 3 frames -> frame_count=3; without it, the build has no frame_count port.

Source files
------------

// File: rtl/gpu_pkg.sv
// Purpose: shared memory-map and frame constants between the column writer and the GPU display side.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package gpu_pkg;

  // Frame geometry. The column index is carried in a fixed 9-bit field.
  localparam int IDX_W           = 9;
  localparam int COLUMNS_DEFAULT = 320;

  // Shared-memory map: two double-buffered column arrays plus one flag word.
  localparam logic [15:0] DISTANCE_1 = 16'd63488;
  localparam logic [15:0] TEXTURE_1  = 16'd64000;
  localparam logic [15:0] DISTANCE_2 = 16'd64512;
  localparam logic [15:0] TEXTURE_2  = 16'd65024;
  localparam logic [15:0] FLAG       = 16'd65535;

  // Flag word layout: consumer sets CONSUMED when it has read the last frame;
  // SELECT names the buffer most recently published.
  localparam int FLAG_CONSUMED_BIT = 0;
  localparam int FLAG_SELECT_BIT   = 1;

  // Buffer base plus zero-extended column index.
  function automatic logic [15:0] col_addr(input logic [15:0] base,
                                           input logic [IDX_W-1:0] idx);
    return base + {{(16 - IDX_W){1'b0}}, idx};
  endfunction

  // Published flag: consumed cleared, select bit naming the buffer just written.
  function automatic logic [15:0] flag_word(input logic target);
    logic [15:0] w;
    w                  = '0;
    w[FLAG_SELECT_BIT] = target;
    return w;
  endfunction

endpackage

// File: rtl/mux4.sv
// Purpose: generic 4:1 combinational multiplexer.
// Latency: combinational, zero cycles.
// Backpressure: none.
// Ports: d0..d3 data inputs (W bits), sel 2-bit select, y selected output.
module mux4 #(
  parameter int W = 16
) (
  input  logic [W-1:0] d0,
  input  logic [W-1:0] d1,
  input  logic [W-1:0] d2,
  input  logic [W-1:0] d3,
  input  logic [1:0]   sel,
  output logic [W-1:0] y
);

  always_comb begin
    y = d0;
    unique case (sel)
      2'd0:    y = d0;
      2'd1:    y = d1;
      2'd2:    y = d2;
      default: y = d3;
    endcase
  end

endmodule

// File: rtl/column_writer.sv
// Purpose: streams one frame of (distance, texture) columns into the free half of a
//          double-buffered shared memory, then publishes the buffer through a flag word.
// Latency: one column per 2 cycles; frame is 2*COLUMNS+1 cycles from first handshake to
//          PUBLISH; col_ready is withheld while polling the flag and during texture writes.
// Ports:
//   clk, clr                    clock and synchronous active-high reset
//   col_valid/col_ready         column handshake; col_distance/col_texture column payload
//   read_address/read_data      shared-memory address (reads and writes), registered read data
//   write_enable/write_data     memory write strobe and word
//   busy, frame_done            activity indicator and post-publish pulse
//   frame_count                 frames published (only with COLUMN_WRITER_FRAME_COUNT_EN)
// Optional feature macro: COLUMN_WRITER_FRAME_COUNT_EN adds the frame_count output.
module column_writer
  import gpu_pkg::*;
#(
  parameter int COLUMNS = COLUMNS_DEFAULT
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        col_valid,
  output logic        col_ready,
  input  logic [15:0] col_distance,
  input  logic [15:0] col_texture,
  output logic [15:0] read_address,
  input  logic [15:0] read_data,
  output logic        write_enable,
  output logic [15:0] write_data,
  output logic        busy,
  output logic        frame_done
`ifdef COLUMN_WRITER_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    POLL_ADDR,
    POLL_CHECK,
    WRITE_DIST,
    WRITE_TEX,
    PUBLISH,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COLUMNS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  // Address mux select; both upper legs carry FLAG.
  localparam logic [1:0] SEL_DIST = 2'd0;
  localparam logic [1:0] SEL_TEX  = 2'd1;
  localparam logic [1:0] SEL_FLAG = 2'd2;

  state_t           state_q,  state_d;
  logic [IDX_W-1:0] index_q,  index_d;
  logic             target_q, target_d;
  logic [15:0]      tex_q,    tex_d;

  logic [1:0]  addr_sel;
  logic [15:0] dist_addr;
  logic [15:0] tex_addr;

  // Only the two flag bits of the memory word are meaningful here.
  logic [13:0] unused_read_data;
  assign unused_read_data = read_data[15:2];

  assign dist_addr = col_addr(target_q ? DISTANCE_2 : DISTANCE_1, index_q);
  assign tex_addr  = col_addr(target_q ? TEXTURE_2  : TEXTURE_1,  index_q);

  mux4 #(.W(16)) u_addr_mux (
    .d0  (dist_addr),
    .d1  (tex_addr),
    .d2  (FLAG),
    .d3  (FLAG),
    .sel (addr_sel),
    .y   (read_address)
  );

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    target_d     = target_q;
    tex_d        = tex_q;
    col_ready    = 1'b0;
    write_enable = 1'b0;
    write_data   = '0;
    busy         = 1'b1;
    frame_done   = 1'b0;
    addr_sel     = SEL_FLAG;

    unique case (state_q)
      IDLE: begin
        busy    = 1'b0;
        index_d = '0;
        if (col_valid) begin
          state_d = POLL_ADDR;
        end
      end

      // FLAG is on the address bus here; the memory returns it next cycle.
      POLL_ADDR: begin
        state_d = POLL_CHECK;
      end

      // Write into the buffer the consumer is not displaying.
      POLL_CHECK: begin
        if (read_data[FLAG_CONSUMED_BIT]) begin
          target_d = ~read_data[FLAG_SELECT_BIT];
          state_d  = WRITE_DIST;
        end else begin
          state_d = POLL_ADDR;
        end
      end

      WRITE_DIST: begin
        col_ready = 1'b1;
        addr_sel  = SEL_DIST;
        if (col_valid) begin
          write_enable = 1'b1;
          write_data   = col_distance;
          tex_d        = col_texture;
          state_d      = WRITE_TEX;
        end
      end

      WRITE_TEX: begin
        addr_sel     = SEL_TEX;
        write_enable = 1'b1;
        write_data   = tex_q;
        if (index_q == LAST_IDX) begin
          state_d = PUBLISH;
        end else begin
          index_d = index_q + IDX_ONE;
          state_d = WRITE_DIST;
        end
      end

      PUBLISH: begin
        write_enable = 1'b1;
        write_data   = flag_word(target_q);
        state_d      = DONE;
      end

      DONE: begin
        frame_done = 1'b1;
        index_d    = '0;
        state_d    = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset forces idle-looking outputs immediately, so a clear landing on a
    // write cycle (including PUBLISH) never reaches memory.
    if (clr) begin
      col_ready    = 1'b0;
      write_enable = 1'b0;
      write_data   = '0;
      busy         = 1'b0;
      frame_done   = 1'b0;
      addr_sel     = SEL_FLAG;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      index_q  <= '0;
      target_q <= 1'b0;
      tex_q    <= '0;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      target_q <= target_d;
      tex_q    <= tex_d;
    end
  end

`ifdef COLUMN_WRITER_FRAME_COUNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Wraps naturally at 16 bits.
  always_comb begin
    frame_count_d = frame_count_q;
    if (state_q == PUBLISH) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_column_writer.sv
module tb_column_writer;

  localparam int NCOL = 320;
  localparam logic [15:0] FLAG_A = 16'hFFFF;

  logic        clk = 1'b0;
  logic        clr;
  logic        col_valid;
  logic        col_ready;
  logic [15:0] col_distance;
  logic [15:0] col_texture;
  logic [15:0] read_address;
  logic [15:0] read_data;
  logic        write_enable;
  logic [15:0] write_data;
  logic        busy;
  logic        frame_done;
`ifdef COLUMN_WRITER_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  column_writer #(.COLUMNS(NCOL)) dut (
    .clk          (clk),
    .clr          (clr),
    .col_valid    (col_valid),
    .col_ready    (col_ready),
    .col_distance (col_distance),
    .col_texture  (col_texture),
    .read_address (read_address),
    .read_data    (read_data),
    .write_enable (write_enable),
    .write_data   (write_data),
    .busy         (busy),
    .frame_done   (frame_done)
`ifdef COLUMN_WRITER_FRAME_COUNT_EN
    ,
    .frame_count  (frame_count)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Shared memory model: synchronous write, one-cycle registered read.
  logic [15:0] mem [0:65535];
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = '0;
  logic [15:0] poke_dat = '0;

  always @(posedge clk) begin
    if (write_enable) mem[read_address] <= write_data;
    if (poke_en) mem[poke_addr] <= poke_dat;
    read_data <= mem[read_address];
  end

  int n_vec = 0;
  int n_err = 0;
  int wr_count = 0;
  int done_count = 0;
  int first_hs_cyc = 0;
  int publish_cyc = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_dist [0:NCOL-1];
  logic [15:0] exp_tex  [0:NCOL-1];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every memory write is popped against the scoreboard.
  always begin
    logic [31:0] e;
    @(negedge clk);
    #2;
    if (write_enable) begin
      wr_count++;
      if (read_address == FLAG_A) publish_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", read_address, write_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(read_address), 32'(e[31:16]));
        check("wr_data", 32'(write_data), 32'(e[15:0]));
      end
    end
    if (frame_done) done_count++;
  end

  task automatic poke(input logic [15:0] a, input logic [15:0] d);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = a; poke_dat = d;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Reference: buffer chosen as the one opposite the published select bit;
  // each accepted column yields a distance write then a texture write.
  task automatic run_frame(input int ncols, input logic [15:0] flag_val, input int pause_at,
                           input bit rnd, input bit publish);
    logic tgt;
    logic [15:0] dbase, tbase, d, t, fexp;
    int i, guard, pause_left, wr_before, done_before;
    tgt = ~flag_val[1];
    dbase = tgt ? 16'd64512 : 16'd63488;
    tbase = tgt ? 16'd65024 : 16'd64000;
    i = 0; guard = 0; pause_left = 10;
    wr_before = wr_count; done_before = done_count;
    while (i < ncols && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (i == pause_at && pause_left > 0) begin
        col_valid = 1'b0;
        #1;
        // First gap cycle is the texture write of the previous column.
        if (pause_left < 10) check("gap_write_enable", 32'(write_enable), 32'd0);
        pause_left--;
      end else begin
        d = rnd ? 16'($urandom) : 16'(i);
        t = rnd ? 16'($urandom) : 16'(16'h0100 + 16'(i));
        col_valid = 1'b1; col_distance = d; col_texture = t;
        #1;
        if (col_ready) begin
          if (i == 0) first_hs_cyc = cyc;
          exp_dist[i] = d;
          exp_tex[i] = t;
          exp_q.push_back({dbase + 16'(i), d});
          exp_q.push_back({tbase + 16'(i), t});
          i++;
        end
      end
    end
    if (i < ncols) begin
      n_vec++; n_err++;
      $display("FAIL frame_accept: accepted %0d columns, expected %0d", i, ncols);
    end
    @(negedge clk);
    col_valid = 1'b0;
    if (publish) begin
      fexp = '0;
      fexp[1] = tgt;
      exp_q.push_back({FLAG_A, fexp});
      guard = 0;
      while (done_count == done_before && guard < 20) begin
        @(negedge clk); #3; guard++;
      end
      check("frame_done_seen", 32'(done_count - done_before), 32'd1);
      @(negedge clk); #3;
      check("frame_done_pulse", 32'(frame_done), 32'd0);
      check("frame_busy_idle", 32'(busy), 32'd0);
      check("frame_writes", 32'(wr_count - wr_before), 32'(2 * ncols + 1));
      check("flag_final", 32'(mem[FLAG_A]), 32'(fexp));
      for (int k = 0; k < ncols; k++) begin
        check("mem_dist", 32'(mem[dbase + 16'(k)]), 32'(exp_dist[k]));
        check("mem_tex", 32'(mem[tbase + 16'(k)]), 32'(exp_tex[k]));
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_col_ready"}, 32'(col_ready), 32'd0);
    check({tag, "_write_enable"}, 32'(write_enable), 32'd0);
    check({tag, "_write_data"}, 32'(write_data), 32'd0);
    check({tag, "_read_address"}, 32'(read_address), 32'hFFFF);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1);
  end

  initial begin
    clr = 1'b1; col_valid = 1'b0; col_distance = '0; col_texture = '0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_outputs("reset_held");
    @(negedge clk);
    clr = 1'b0;
    #1;
    check_idle_outputs("reset_released");

    // Frame A: flag consumed, select 0 -> buffer 2, deterministic data.
    poke(FLAG_A, 16'h0001);
    run_frame(NCOL, 16'h0001, -1, 1'b0, 1'b1);
    check("frame_latency", 32'(publish_cyc - first_hs_cyc), 32'(2 * NCOL));

    // Frame B: flag select 1 -> buffer 1, random data.
    poke(FLAG_A, 16'h0003);
    run_frame(NCOL, 16'h0003, -1, 1'b1, 1'b1);

    // Frame C: flag unconsumed (0 after frame B); writer must keep polling.
    col_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      check("poll_col_ready", 32'(col_ready), 32'd0);
      check("poll_write_enable", 32'(write_enable), 32'd0);
      if (k > 2) check("poll_busy", 32'(busy), 32'd1);
    end
    poke(FLAG_A, 16'h0001);
    run_frame(NCOL, 16'h0001, -1, 1'b1, 1'b1);

    // Frame D: producer stalls for 10 cycles at column 100.
    poke(FLAG_A, 16'h0001);
    run_frame(NCOL, 16'h0001, 100, 1'b1, 1'b1);

    // Frame E: reset at column 200 abandons the frame without publishing.
    poke(FLAG_A, 16'h0001);
    run_frame(200, 16'h0001, -1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("abort_queue_drained", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    clr = 1'b1;
    #1;
    check_idle_outputs("abort_clr");
    @(negedge clk);
    clr = 1'b0;
    #1;
    check_idle_outputs("abort_after");
    repeat (3) @(negedge clk);
    check("abort_no_flag_write", 32'(mem[FLAG_A]), 32'h0001);
    run_frame(NCOL, 16'h0001, -1, 1'b1, 1'b1);

`ifdef COLUMN_WRITER_FRAME_COUNT_EN
    check("frame_count", 32'(frame_count), 32'd5);
`endif
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
